// File: rtl/sram_arbiter.sv
// Two-into-one arbiter sharing one sram-like port between instruction fetch and data access.
// Responses return in order; a small owner FIFO routes each one to the requester that issued it.
module sram_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            inst_req,
    input  logic                                            inst_wr,
    input  logic [1:0]                                      inst_size,
    input  logic [31:0]                                     inst_addr,
    input  logic [3:0]                                      inst_wstrb,
    input  logic [31:0]                                     inst_wdata,
    output logic                                            inst_addr_ok,
    output logic                                            inst_data_ok,
    output logic [31:0]                                     inst_rdata,
    input  logic                                            data_req,
    input  logic                                            data_wr,
    input  logic [1:0]                                      data_size,
    input  logic [31:0]                                     data_addr,
    input  logic [3:0]                                      data_wstrb,
    input  logic [31:0]                                     data_wdata,
    output logic                                            data_addr_ok,
    output logic                                            data_data_ok,
    output logic [31:0]                                     data_rdata,
    output logic                                            mem_req,
    output logic                                            mem_wr,
    output logic [1:0]                                      mem_size,
    output logic [31:0]                                     mem_addr,
    output logic [3:0]                                      mem_wstrb,
    output logic [31:0]                                     mem_wdata,
    input  logic                                            mem_addr_ok,
    input  logic                                            mem_data_ok,
    input  logic [31:0]                                     mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]                      dbg_count,
    output logic [((STARVE_MAX > 0) ? $clog2(STARVE_MAX+1) : 1)-1:0] dbg_starve,
    output logic                                            dbg_lock
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {
        ARB_OPEN,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic             lock_owner_q, lock_owner_d;
    logic [DEPTH-1:0] owner_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [STV_W-1:0] starve_q;

    logic full, grant_data, sel_req, handshake, pop, head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // grant_data: 1 = data requester owns the port this cycle, 0 = inst.
    always_comb begin
        grant_data = 1'b0;
        if (state_q == ARB_LOCKED)
            grant_data = lock_owner_q;
        else if (starve_q == STV_W'(STARVE_MAX) && inst_req)
            grant_data = 1'b0;
        else if (data_req)
            grant_data = 1'b1;
    end

    assign full       = (count_q == CNT_W'(DEPTH));
    assign sel_req    = grant_data ? data_req : inst_req;
    assign mem_req    = !reset && !full && sel_req;
    assign handshake  = mem_req && mem_addr_ok;
    assign pop        = !reset && mem_data_ok && (count_q != '0);
    assign head_owner = owner_q[rd_ptr_q];

    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = handshake && !grant_data;
    assign data_addr_ok = handshake && grant_data;
    assign inst_data_ok = pop && !head_owner;
    assign data_data_ok = pop && head_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign dbg_count  = count_q;
    assign dbg_starve = starve_q;
    assign dbg_lock   = (state_q == ARB_LOCKED);

    // A rejected request pins the grant so the presented address cannot switch.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        if (handshake) begin
            state_d = ARB_OPEN;
        end else if (mem_req) begin
            state_d      = ARB_LOCKED;
            lock_owner_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_OPEN;
            lock_owner_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            if (handshake) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({handshake, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (!inst_req)
                starve_q <= '0;
            else if (handshake && grant_data) begin
                if (starve_q != STV_W'(STARVE_MAX)) starve_q <= starve_q + 1'b1;
            end else if (handshake)
                starve_q <= '0;
        end
    end

    // Owner bits are pure storage; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (handshake) owner_q[wr_ptr_q] <= grant_data;
    end

endmodule
